// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl
//   Upstream stage of the snake/background renderer. Turns held USB keycodes
//   and the per-frame vsync tick into a grid-stepped snake-head position,
//   size and heading. Owns the game-state FSM (IDLE, RUN, DEAD), including
//   wall collision.
//
// Ports
//   Clk         in   1   system clock
//   Reset       in   1   synchronous, active-high reset
//   frame_clk   in   1   raw vsync-rate tick, asynchronous to Clk
//   keycode     in   8   current keyboard keycode, level-held
//   snakeX_pos  out  10  head centre X
//   snakeY_pos  out  10  head centre Y
//   snake_size  out  10  constant HALF_SIZE
//   motion_dir  out  2   heading: 00=W/up, 01=A/left, 10=S/down, 11=D/right
//   step_pulse  out  1   one-Clk pulse on each applied move
//   dead        out  1   high while in DEAD
//
// Configuration
//   SNAKE_WRAP_EN : when defined, the head wraps at the walls instead of
//                   dying, so DEAD is never entered.
module snake_motion_ctrl #(
    parameter int X_START         = 320,
    parameter int Y_START         = 240,
    parameter int HALF_SIZE       = 12,
    parameter int STEP            = 24,
    parameter int FRAMES_PER_STEP = 8,
    parameter int X_MIN           = 12,
    parameter int X_MAX           = 627,
    parameter int Y_MIN           = 12,
    parameter int Y_MAX           = 467
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] snakeX_pos,
    output logic [9:0] snakeY_pos,
    output logic [9:0] snake_size,
    output logic [1:0] motion_dir,
    output logic       step_pulse,
    output logic       dead
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [9:0]        X_START_V  = 10'(X_START);
    localparam logic [9:0]        Y_START_V  = 10'(Y_START);
    localparam logic [7:0]        LAST_FRAME = 8'(FRAMES_PER_STEP - 1);
    localparam logic signed [10:0] STEP_S    = 11'(STEP);
    localparam logic signed [10:0] XMIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S    = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S    = 11'(Y_MAX);

    state_t      state, state_n;
    logic [9:0]  x_reg, x_n, y_reg, y_n;
    logic [1:0]  dir_reg, dir_n, pend_reg, pend_n;
    logic [7:0]  cnt_reg, cnt_n;
    logic        pulse_reg, pulse_n;
    logic        sync1, sync2, sync3;
    logic        frame_edge;

    logic        key_wasd, key_space;
    logic [1:0]  key_dir;
    logic signed [10:0] nx, ny;
    logic        move_ok;
`ifndef SNAKE_WRAP_EN
    logic        in_range;
`endif

    // sync1/sync2 resynchronise frame_clk; sync3 delays it once more so the
    // rising edge shows up as a single-cycle pulse.
    assign frame_edge = sync2 & ~sync3;

    always_comb begin
        key_wasd  = 1'b0;
        key_space = 1'b0;
        key_dir   = 2'b00;
        case (keycode)
            8'h1A: begin key_wasd = 1'b1; key_dir = 2'b00; end
            8'h04: begin key_wasd = 1'b1; key_dir = 2'b01; end
            8'h16: begin key_wasd = 1'b1; key_dir = 2'b10; end
            8'h07: begin key_wasd = 1'b1; key_dir = 2'b11; end
            8'h2C: key_space = 1'b1;
            default: ;
        endcase
    end

    // Candidate position for the next step, in signed 11 bits so that a
    // move past zero is seen as negative rather than wrapping to a large value.
    always_comb begin
        nx = $signed({1'b0, x_reg});
        ny = $signed({1'b0, y_reg});
        case (pend_reg)
            2'b00:   ny = ny - STEP_S;
            2'b01:   nx = nx - STEP_S;
            2'b10:   ny = ny + STEP_S;
            default: nx = nx + STEP_S;
        endcase
`ifdef SNAKE_WRAP_EN
        if (nx < XMIN_S)      nx = XMAX_S;
        else if (nx > XMAX_S) nx = XMIN_S;
        if (ny < YMIN_S)      ny = YMAX_S;
        else if (ny > YMAX_S) ny = YMIN_S;
        move_ok = 1'b1;
`else
        in_range = (nx >= XMIN_S) && (nx <= XMAX_S) &&
                   (ny >= YMIN_S) && (ny <= YMAX_S);
        move_ok  = in_range;
`endif
    end

    always_comb begin
        state_n = state;
        x_n     = x_reg;
        y_n     = y_reg;
        dir_n   = dir_reg;
        pend_n  = pend_reg;
        cnt_n   = cnt_reg;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                x_n   = X_START_V;
                y_n   = Y_START_V;
                cnt_n = 8'd0;
                // A frame_edge in this cycle is deliberately not counted.
                if (key_wasd) begin
                    dir_n   = key_dir;
                    pend_n  = key_dir;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (frame_edge && (cnt_reg == LAST_FRAME)) begin
                    // Step cycle: keys are ignored here.
                    cnt_n = 8'd0;
                    if (move_ok) begin
                        x_n     = nx[9:0];
                        y_n     = ny[9:0];
                        dir_n   = pend_reg;
                        pulse_n = 1'b1;
                    end else begin
                        state_n = DEAD;
                    end
                end else begin
                    if (frame_edge)
                        cnt_n = cnt_reg + 8'd1;
                    // Only perpendicular turns are accepted; flipping bit 1
                    // of a heading gives its exact opposite.
                    if (key_wasd && (key_dir != dir_reg) &&
                        (key_dir != (dir_reg ^ 2'b10)))
                        pend_n = key_dir;
                end
            end
            DEAD: begin
                if (key_space) begin
                    state_n = IDLE;
                    x_n     = X_START_V;
                    y_n     = Y_START_V;
                    dir_n   = 2'b00;
                    pend_n  = 2'b00;
                    cnt_n   = 8'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            x_reg     <= X_START_V;
            y_reg     <= Y_START_V;
            dir_reg   <= 2'b00;
            pend_reg  <= 2'b00;
            cnt_reg   <= 8'd0;
            pulse_reg <= 1'b0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
        end else begin
            state     <= state_n;
            x_reg     <= x_n;
            y_reg     <= y_n;
            dir_reg   <= dir_n;
            pend_reg  <= pend_n;
            cnt_reg   <= cnt_n;
            pulse_reg <= pulse_n;
            sync1     <= frame_clk;
            sync2     <= sync1;
            sync3     <= sync2;
        end
    end

    assign snakeX_pos = x_reg;
    assign snakeY_pos = y_reg;
    assign snake_size = 10'(HALF_SIZE);
    assign motion_dir = dir_reg;
    assign step_pulse = pulse_reg;
    assign dead       = (state == DEAD);

endmodule

// File: doc/snake_motion_ctrl.md
Name: snake_motion_ctrl

Overview:
- Upstream stage of the snake/background renderer.
- Turns held USB keycodes and the per-frame vertical-sync tick into a grid-stepped snake-head position, size and heading.
- Outputs feed the renderer's snakeX_pos/snakeY_pos/snake_size inputs and its 2-bit head-sprite select directly.
- Owns the game-state FSM (idle, running, dead), including wall collision.

Parameters:
- X_START, 320: head centre X after reset/restart.
- Y_START, 240: head centre Y after reset/restart.
- HALF_SIZE, 12: half-width of the 24x24 head sprite; driven on snake_size.
- STEP, 24: pixels moved per step (one grid cell).
- FRAMES_PER_STEP, 8: frame ticks per movement step; legal range 1..255.
- X_MIN / X_MAX, 12 / 627: legal head-centre X range, inclusive.
- Y_MIN / Y_MAX, 12 / 467: legal head-centre Y range, inclusive.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  raw vsync-rate tick, asynchronous to Clk.
- keycode  in  8  current keyboard keycode, level-held.
- snakeX_pos  out  10  head centre X.
- snakeY_pos  out  10  head centre Y.
- snake_size  out  10  constant HALF_SIZE.
- motion_dir  out  2  heading: 00=W/up, 01=A/left, 10=S/down, 11=D/right.
- step_pulse  out  1  one-Clk pulse on each applied move.
- dead  out  1  high while in DEAD.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high, sampled on the rising edge of Clk, and has priority over every other event.
- Reset values:
  - snakeX_pos = X_START, snakeY_pos = Y_START.
  - motion_dir = 00, pending_dir = 00.
  - step_pulse = 0, dead = 0.
  - frame counter = 0, synchronizer flops = 0, state = IDLE.
- snake_size is tied to HALF_SIZE at all times.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer plus a third flop.
  - frame_edge = sync2 & ~sync3, high for exactly one Clk per rising edge of frame_clk.
- Key decode: 8'h1A=W, 8'h04=A, 8'h16=S, 8'h07=D, 8'h2C=SPACE. All other codes are ignored.
- IDLE:
  - Position is held at start values; the frame counter is held at 0.
  - A WASD key loads that direction into both motion_dir and pending_dir, then the FSM goes to RUN on the next cycle.
  - SPACE is ignored.
- RUN, key handling:
  - Every cycle except a step cycle, a WASD key whose direction is not the exact opposite of the current motion_dir loads pending_dir.
  - A key for the opposite direction, or for the same direction, leaves pending_dir unchanged.
  - The last accepted key before a step wins.
  - Keys in the step cycle are ignored. Because keycode is level-held, a held key is re-sampled on the next cycle.
- RUN, frame counting:
  - On frame_edge, the counter increments.
  - When frame_edge arrives with counter == FRAMES_PER_STEP-1, that cycle is the step cycle and the counter returns to 0.
- RUN, step cycle:
  - Compute the next position from pending_dir using 11-bit signed arithmetic:
    - W: Y-STEP
    - S: Y+STEP
    - A: X-STEP
    - D: X+STEP
  - If the next position is in range, the registers update on the following edge: position <= next, motion_dir <= pending_dir, step_pulse = 1 for one cycle. New values and step_pulse are visible together, one Clk after the step cycle.
  - If the next position is outside [X_MIN,X_MAX] or [Y_MIN,Y_MAX]: position and motion_dir hold, state goes to DEAD, dead = 1, and no step_pulse is produced.
- DEAD:
  - All outputs hold and the frame counter is frozen.
  - SPACE returns the FSM to IDLE on the next edge, restoring start values, motion_dir = 00 and dead = 0.
  - WASD is ignored.
- Simultaneous events:
  - Reset beats SPACE, keys and frame_edge.
  - A frame_edge in the same cycle as the IDLE->RUN transition is not counted.
- Reset mid-step: if Reset coincides with a step cycle, no move is applied and all outputs take their reset values.

Optional Feature:
- Macro name: SNAKE_WRAP_EN.
- Defined: edges wrap and no wall collision occurs, so DEAD is unreachable and dead stays 0.
  - An X move that would land below X_MIN lands at X_MAX; an X move that would land above X_MAX lands at X_MIN.
  - Y wraps the same way between Y_MIN and Y_MAX.
  - step_pulse still fires on every wrapped move.
- Undefined: walls are lethal, as described in Behaviour.

Test Plan:
- Reset, then hold keycode 8'h07 (D) with FRAMES_PER_STEP=8 and 16 frame ticks -> two step_pulses; X goes 320->344->368; Y stays 240; motion_dir=11.
- RUN heading S, press 8'h1A (W) before a step -> reversal rejected; the next step gives Y=264 and motion_dir stays 10.
- RUN heading D, press A then W within one step interval -> pending settles on W; the next step gives Y=216 and motion_dir=00.
- Heading A from X=32 -> the next step would give X=8 < 12 -> dead=1, no step_pulse, X holds at 32. Then keycode 8'h2C -> next cycle back in IDLE: X=320, Y=240, dead=0.
- Assert Reset on the same cycle as a step-cycle frame_edge -> no move is applied; outputs equal reset values one cycle later.
- With SNAKE_WRAP_EN defined, heading A from X=32 -> the next step gives X=627, dead=0, step_pulse=1.
